// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the generic pipeline stage register.
// Occupancy-coded states plus the RV32 NOP used as an instruction bubble.
package pipe_stage_skid_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_skid.sv
// Parametrised valid/ready pipeline stage with optional 2-entry skid buffer.
// Flush squashes everything held and anything arriving in the same cycle.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int                DATA_W  = 32,
   parameter logic [DATA_W-1:0] BUBBLE  = '0,
   parameter int                SKID_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic              flush_kill
);

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_q;
   logic [DATA_W-1:0] skid_d;
   logic              in_fire;
   logic              out_fire;

   assign out_valid  = (state_q != ST_EMPTY);
   assign out_data   = out_valid ? main_q : BUBBLE;
   assign occupancy  = state_q;
   assign in_fire    = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;
   assign flush_kill = flush & (out_valid | in_fire);

   // Next state and next payload from flush and both handshakes.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_HALF;
                  main_d  = in_data;
               end
            end
            ST_HALF: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  if (SKID_EN != 0) begin
                     state_d = ST_FULL;
                     skid_d  = in_data;
                  end
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
                  main_d  = BUBBLE;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_d = ST_HALF;
                  main_d  = skid_q;
                  skid_d  = BUBBLE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = BUBBLE;
               skid_d  = BUBBLE;
            end
         endcase
      end
   end

   // State and payload registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         main_q  <= BUBBLE;
         skid_q  <= BUBBLE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   generate
      if (SKID_EN != 0) begin : g_skid
         logic rdy_q;

         // Ready is a flop: the skid slot absorbs the stall one cycle late.
         always_ff @(posedge clk) begin
            if (reset) begin
               rdy_q <= 1'b1;
            end else begin
               rdy_q <= (state_d != ST_FULL);
            end
         end

         assign in_ready = rdy_q;
      end else begin : g_flow
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid (32b) and flow-through (64b) instances
// checked each cycle against queue models, plus directed literal checks.
module tb_pipe_stage_skid;
   import pipe_stage_skid_pkg::*;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic        flush_kill;

   logic        z_flush;
   logic        z_in_valid;
   logic        z_in_ready;
   logic [63:0] z_in_data;
   logic        z_out_valid;
   logic        z_out_ready;
   logic [63:0] z_out_data;
   logic [1:0]  z_occupancy;
   logic        z_flush_kill;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   logic [31:0] mq[$];
   logic [63:0] zq[$];
   bit          stall_last;
   logic [31:0] held_last;

   pipe_stage_skid #(
      .DATA_W (32),
      .BUBBLE (RV_NOP),
      .SKID_EN(1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .flush_kill(flush_kill)
   );

   pipe_stage_skid #(
      .DATA_W (64),
      .BUBBLE ('0),
      .SKID_EN(0)
   ) dut0 (
      .clk       (clk),
      .reset     (reset),
      .flush     (z_flush),
      .in_valid  (z_in_valid),
      .in_ready  (z_in_ready),
      .in_data   (z_in_data),
      .out_valid (z_out_valid),
      .out_ready (z_out_ready),
      .out_data  (z_out_data),
      .occupancy (z_occupancy),
      .flush_kill(z_flush_kill)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic go;
      @(posedge clk);
      #1;
   endtask

   // Reference: a stage is a FIFO holding at most 2 (skid) or 1 (flow) items.
   always @(posedge clk) begin
      bit m_in, m_out, z_in, z_out;
      stall_last = !reset && !flush && (mq.size() > 0) && !out_ready;
      held_last  = (mq.size() > 0) ? mq[0] : RV_NOP;
      if (reset) begin
         mq.delete();
         zq.delete();
      end else begin
         m_in  = in_valid && (mq.size() < 2);
         m_out = (mq.size() > 0) && out_ready;
         if (flush) mq.delete();
         else begin
            if (m_out) void'(mq.pop_front());
            if (m_in) mq.push_back(in_data);
         end
         z_in  = z_in_valid && ((zq.size() == 0) || z_out_ready);
         z_out = (zq.size() > 0) && z_out_ready;
         if (z_flush) zq.delete();
         else begin
            if (z_out) void'(zq.pop_front());
            if (z_in) zq.push_back(z_in_data);
         end
      end
   end

   // Compare both DUTs to the queue models mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         bit e_v, e_rdy, z_v, z_rdy;
         e_v   = mq.size() > 0;
         e_rdy = mq.size() < 2;
         chk("m_valid", out_valid, e_v);
         chk("m_data", out_data, e_v ? mq[0] : RV_NOP);
         chk("m_occ", occupancy, mq.size());
         chk("m_ready", in_ready, e_rdy);
         chk("m_kill", flush_kill, flush && (e_v || (in_valid && e_rdy)));
         if (stall_last) begin
            chk("m_stable_v", out_valid, 1'b1);
            chk("m_stable_d", out_data, held_last);
         end
         z_v   = zq.size() > 0;
         z_rdy = !z_v || z_out_ready;
         chk("z_valid", z_out_valid, z_v);
         chk("z_data", z_out_data, z_v ? zq[0] : 64'd0);
         chk("z_occ", z_occupancy, zq.size());
         chk("z_ready", z_in_ready, z_rdy);
         chk("z_kill", z_flush_kill, z_flush && (z_v || (z_in_valid && z_rdy)));
      end
   end

   initial begin
      reset = 1; flush = 0; in_valid = 1; in_data = 32'h55; out_ready = 1;
      z_flush = 0; z_in_valid = 0; z_in_data = '0; z_out_ready = 1;

      repeat (3) begin
         go;
         chk_en = 1;
         @(negedge clk);
         chk("rst_valid", out_valid, 1'b0);
         chk("rst_data", out_data, RV_NOP);
         chk("rst_occ", occupancy, 2'd0);
      end
      go; reset = 0; in_valid = 0;
      @(negedge clk); chk("rst_ready", in_ready, 1'b1);

      go; in_valid = 1; in_data = 32'd1; out_ready = 1;
      @(negedge clk); chk("s_ready", in_ready, 1'b1);
      go; in_data = 32'd2;
      @(negedge clk); chk("s_d1", out_data, 32'd1); chk("s_occ1", occupancy, 2'd1);
      go; in_data = 32'd3;
      @(negedge clk); chk("s_d2", out_data, 32'd2); chk("s_occ2", occupancy, 2'd1);
      go; in_valid = 0;
      @(negedge clk); chk("s_d3", out_data, 32'd3);
      go;
      @(negedge clk); chk("s_empty", out_valid, 1'b0); chk("s_bub", out_data, RV_NOP);

      go; out_ready = 0; in_valid = 1; in_data = 32'hA;
      @(negedge clk); chk("k_rdy0", in_ready, 1'b1);
      go; in_data = 32'hB;
      @(negedge clk); chk("k_dA0", out_data, 32'hA); chk("k_rdy1", in_ready, 1'b1);
      go; in_valid = 0;
      @(negedge clk); chk("k_occ2", occupancy, 2'd2); chk("k_rdy2", in_ready, 1'b0);
      chk("k_dA1", out_data, 32'hA);
      go;
      @(negedge clk); chk("k_dA2", out_data, 32'hA);
      go; out_ready = 1;
      @(negedge clk); chk("k_dA3", out_data, 32'hA);
      go;
      @(negedge clk); chk("k_dB", out_data, 32'hB); chk("k_occ1", occupancy, 2'd1);
      chk("k_rdy3", in_ready, 1'b1);
      go;
      @(negedge clk); chk("k_empty", out_valid, 1'b0);

      go; out_ready = 0; in_valid = 1; in_data = 32'hC1;
      go; in_data = 32'hC2;
      go; in_data = 32'hC3; flush = 1;
      @(negedge clk); chk("f_occ2", occupancy, 2'd2); chk("f_kill", flush_kill, 1'b1);
      go; flush = 0; in_valid = 0;
      @(negedge clk); chk("f_occ0", occupancy, 2'd0); chk("f_valid", out_valid, 1'b0);
      chk("f_bub", out_data, RV_NOP);
      go;
      @(negedge clk); chk("f_gone", out_valid, 1'b0);
      go; flush = 1; in_valid = 1; in_data = 32'hD;
      @(negedge clk); chk("f_kill_in", flush_kill, 1'b1);
      go; flush = 0; in_valid = 0;
      @(negedge clk); chk("f_drop", out_valid, 1'b0);
      go; flush = 1;
      @(negedge clk); chk("f_idle", flush_kill, 1'b0);
      go; flush = 0; out_ready = 1;

      go; z_in_valid = 1; z_in_data = 64'h1111_2222_3333_4444; z_out_ready = 0;
      @(negedge clk); chk("z_rdy_e", z_in_ready, 1'b1);
      go; z_in_data = 64'h5555_6666_7777_8888;
      @(negedge clk); chk("z_rdy_stall", z_in_ready, 1'b0);
      chk("z_d0", z_out_data, 64'h1111_2222_3333_4444);
      go; z_out_ready = 1;
      @(negedge clk); chk("z_rdy_go", z_in_ready, 1'b1);
      chk("z_d0b", z_out_data, 64'h1111_2222_3333_4444);
      go; z_in_data = 64'h9999_AAAA_BBBB_CCCC;
      @(negedge clk); chk("z_d1", z_out_data, 64'h5555_6666_7777_8888);
      go; z_in_valid = 0;
      @(negedge clk); chk("z_d2", z_out_data, 64'h9999_AAAA_BBBB_CCCC);
      go;
      @(negedge clk); chk("z_empty", z_out_valid, 1'b0);

      repeat (10000) begin
         go;
         in_valid    = ($urandom_range(0, 9) < 7);
         in_data     = $urandom;
         out_ready   = ($urandom_range(0, 9) < 6);
         flush       = ($urandom_range(0, 31) == 0);
         z_in_valid  = ($urandom_range(0, 9) < 7);
         z_in_data   = {$urandom, $urandom};
         z_out_ready = ($urandom_range(0, 9) < 6);
         z_flush     = ($urandom_range(0, 31) == 0);
      end
      go;
      in_valid = 0; flush = 0; out_ready = 1;
      z_in_valid = 0; z_flush = 0; z_out_ready = 1;
      repeat (4) go;
      @(negedge clk);
      chk("drain", out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
